// File: rtl/wisc_pkg.sv
// Shared decode constants and helpers for the hazard scoreboard.
// Opcode values are the architectural encodings seen in decode.
package wisc_pkg;
    localparam int CNT_W = 3;

    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_BR  = 4'hD;

    // Shifts/rotates and every opcode with bit 3 set carry an immediate in the src2 slot.
    function automatic logic src2_unused(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR) || op[3];
    endfunction
endpackage

// File: rtl/sb_entry.sv
// One register's pending-result countdown and load flag.
// Latency: state visible the cycle after issue; no backpressure, issue always overrides decrement.
module sb_entry
    import wisc_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int BR_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  logic             is_load_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ld_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_q, ld_d;

    always_comb begin
        cnt_d = cnt_q;
        ld_d  = ld_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) ld_d = 1'b0;
        end
        // Newest writer wins over the running countdown.
        if (issue_i) begin
            cnt_d = is_load_i ? CNT_W'(LOAD_LAT) : CNT_W'(BR_LAT);
            ld_d  = is_load_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ld_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ld_o  = ld_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: stalls on pending load results and on ALU results feeding a register branch.
// Latency: stall_en is combinational from decode inputs; stats (HAZARD_STATS_EN) are registered.
module hazard_scoreboard
    import wisc_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int LOAD_LAT = 1,
    parameter int BR_LAT   = 1,
    localparam int REG_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       dec_opcode,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic [REG_W-1:0] dst,
    input  logic             dst_wr,
    input  logic             is_load,
    input  logic             dec_valid,
    input  logic             flush,
    output logic             stall_en,
    output logic [15:0]      stall_cycles,
    output logic             watchdog_err
);
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] ld;
    logic                is_br, hit1, hit2, issue;

    // R0 is hardwired and never pending.
    assign cnt[0] = '0;
    assign ld[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .LOAD_LAT (LOAD_LAT),
            .BR_LAT   (BR_LAT)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .issue_i   (issue && dst_wr && (dst == REG_W'(r))),
            .is_load_i (is_load),
            .cnt_o     (cnt[r]),
            .ld_o      (ld[r])
        );
    end

    assign is_br    = (dec_opcode == OP_BR);
    assign hit1     = (cnt[src1] != '0) && (ld[src1] || is_br);
    assign hit2     = !src2_unused(dec_opcode) && (cnt[src2] != '0) && (ld[src2] || is_br);
    assign stall_en = !rst && dec_valid && !flush && (hit1 || hit2);
    assign issue    = dec_valid && !flush && !stall_en;

`ifdef HAZARD_STATS_EN
    localparam int WD_LIMIT = LOAD_LAT + BR_LAT + 1;

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [4:0]  run_q, run_d;
    logic        wd_q, wd_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_d       = '0;
        if (stall_en) begin
            if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
            run_d = (run_q == 5'd31) ? run_q : run_q + 5'd1;
        end
        wd_d = wd_q || (run_d > 5'(WD_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            run_q       <= '0;
            wd_q        <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            wd_q        <= wd_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign watchdog_err = wd_q;
`else
    assign stall_cycles = '0;
    assign watchdog_err = 1'b0;
`endif
endmodule
